// File: rtl/servo_driver.sv
// servo_driver: single-shot hobby-servo PWM frame generator.
// One accepted start produces one frame: o_pulse high for the latched
// number of cycles (clamped to the frame), then low until the frame ends.
// o_done is high only while idle and ready for the next start.
module servo_driver #(
  parameter int T_CLK   = 10,
  parameter int T_FRAME = 20_000_000
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [31:0] i_pulseWidth,
  output logic        o_done,
  output logic        o_pulse
);

  localparam logic [31:0] FRAME_CYCLES = 32'(T_FRAME / T_CLK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] width_q, width_d;
  logic        pulse_q, done_q;

  // State, counter, latched width and the output flops; reset cuts the pulse at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      count_q <= '0;
      width_q <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      width_q <= width_d;
      pulse_q <= (state_d == HIGH);
      done_q  <= (state_d == IDLE);
    end
  end

  // Next-state logic; the frame-length check wins over the width check so
  // an oversized width is clamped to the frame and the counter never wraps.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    width_d = width_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          width_d = i_pulseWidth;
          count_d = 32'd1;
          state_d = (i_pulseWidth != 32'd0) ? HIGH : LOW;
        end
      end
      HIGH: begin
        count_d = count_q + 32'd1;
        if (count_q == FRAME_CYCLES) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == width_q) begin
          state_d = LOW;
        end
      end
      LOW: begin
        count_d = count_q + 32'd1;
        if (count_q == FRAME_CYCLES) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign o_pulse = pulse_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_servo_driver.sv
// Testbench for servo_driver with a shortened frame (4200 cycles) so the
// whole run stays small. A behavioural model tracks "cycles since the
// accepting edge" and derives expected outputs from the frame rules.
module tb_servo_driver;

  localparam int          T_CLK   = 10;
  localparam int          T_FRAME = 42_000;
  localparam int unsigned F       = T_FRAME / T_CLK;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [31:0] pulseWidth;
  logic        done;
  logic        pulse;

  int checks;
  int errors;

  // Reference model: idle flag, edges since acceptance, accepted width.
  bit          modelIdle;
  int unsigned modelK;
  logic [31:0] modelW;
  int unsigned highCount;

  servo_driver #(
    .T_CLK  (T_CLK),
    .T_FRAME(T_FRAME)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .i_pulseWidth(pulseWidth),
    .o_done      (done),
    .o_pulse     (pulse)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int unsigned clampWidth(input logic [31:0] w);
    return (w < 32'(F)) ? int'(w) : F;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input logic s, input logic [31:0] w);
    logic expPulse;
    start      = s;
    pulseWidth = w;
    @(posedge clk);
    if (modelIdle) begin
      if (s) begin
        modelIdle = 1'b0;
        modelK    = 0;
        modelW    = w;
      end
    end else begin
      modelK++;
      if (modelK >= F) modelIdle = 1'b1;
    end
    #1;
    expPulse = !modelIdle && (modelK < clampWidth(modelW));
    if (pulse === 1'b1) highCount++;
    checkEq("outputs {pulse,done}", {30'd0, pulse, done}, {30'd0, expPulse, modelIdle});
  endtask

  // One full frame started with width w; optional noise on start/width while busy.
  task automatic runFrame(input string tag, input logic [31:0] w, input bit noisy);
    highCount = 0;
    step(1'b1, w);
    for (int k = 1; k <= int'(F); k++) begin
      if (noisy) step(1'($urandom), $urandom);
      else       step(1'b0, 32'd0);
    end
    checkEq({tag, " high time"}, highCount, clampWidth(w));
    checkEq({tag, " done at end"}, {31'd0, done}, 32'd1);
    step(1'b0, 32'd0);
  endtask

  task automatic applyReset();
    rstn = 1'b0;
    modelIdle = 1'b1;
    modelK    = 0;
    modelW    = '0;
  endtask

  initial begin
    logic [31:0] w;
    checks = 0;
    errors = 0;
    start = 1'b0;
    pulseWidth = '0;

    // Reset held for 100 ns.
    applyReset();
    #100;
    checkEq("reset pulse", {31'd0, pulse}, 32'd0);
    checkEq("reset done", {31'd0, done}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) step(1'b0, $urandom);

    // Directed widths, including clamp and zero-width boundaries.
    runFrame("w 0xF", 32'h0000_000F, 1'b0);
    runFrame("w 0xFF", 32'h0000_00FF, 1'b0);
    runFrame("w 0xFFF", 32'h0000_0FFF, 1'b0);
    runFrame("w 0xFFFF clamp", 32'h0000_FFFF, 1'b0);
    runFrame("w 0", 32'h0000_0000, 1'b0);
    runFrame("w max", 32'hFFFF_FFFF, 1'b0);
    runFrame("w F exact", 32'(F), 1'b0);

    // Start and width noise while busy must not disturb the frame.
    runFrame("noisy", 32'd1000 + ($urandom % 2000), 1'b1);

    // Abort mid-pulse: reset asserted between edges takes effect at once.
    step(1'b1, 32'd300);
    repeat (50) step(1'b0, 32'd0);
    checkEq("pre-abort pulse", {31'd0, pulse}, 32'd1);
    #3;
    applyReset();
    #1;
    checkEq("abort pulse", {31'd0, pulse}, 32'd0);
    checkEq("abort done", {31'd0, done}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 32'd0);
    runFrame("after abort", 32'd77, 1'b0);

    // Back-to-back frames with start held high.
    for (int i = 0; i < 2 * (int'(F) + 1) + 3; i++) step(1'b1, 32'd1 + ($urandom % 600));
    repeat (int'(F) + 2) step(1'b0, 32'd0);

    // Random widths, some beyond the frame length.
    for (int i = 0; i < 2; i++) begin
      w = $urandom_range(0, 6000);
      runFrame("random", w, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
